mmio_bridge: RTL and testbench
==============================

# mmio_bridge

Parametrised, registered successor to the combinational MMIO slot controller. Decodes FPro MMIO bus requests into per-slot strobes and adds a slot acknowledge handshake, a bus-timeout watchdog, out-of-range detection and a registered read-data return. Sits between the CPU-side FPro bus and the array of MMIO slot cores; one request in flight at a time.

## Interface
- N_SLOTS, 64: number of slots; legal 2..2**SLOT_AW
- SLOT_AW, 6: slot address width, taken from mmio_addr[REG_AW+SLOT_AW-1:REG_AW]
- REG_AW, 5: register address width, taken from mmio_addr[REG_AW-1:0]
- DW, 32: data width
- TIMEOUT, 16: ACCESS cycles without ack before an error response; ≥ 1
- clk  in  1  clock; single clock domain
- reset  in  1  synchronous, active-high reset
- mmio_cs / mmio_rd / mmio_wr  in  1 each  request qualifiers
- mmio_addr  in  21  bus address; bits above REG_AW+SLOT_AW ignored
- mmio_wr_data  in  DW  write data
- mmio_rd_data  out  DW  registered read data; valid while mmio_ready=1
- mmio_ready  out  1  one-cycle completion pulse
- mmio_err  out  1  qualifies mmio_ready: timeout, out of range, or rd&wr
- slot_cs_array  out  N_SLOTS  one-hot select, held for the whole access
- slot_mem_rd_array / slot_mem_wr_array  out  N_SLOTS  one-cycle strobes, broadcast
- slot_reg_addr_array  out  [N_SLOTS][REG_AW]  registered register address, broadcast
- slot_wr_data_array  out  [N_SLOTS][DW]  registered write data, broadcast
- slot_rd_data_array  in  [N_SLOTS][DW]  slot read data
- slot_ack_array  in  N_SLOTS  slot completion; only the selected slot's bit is observed

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE: when mmio_cs & (mmio_rd|mmio_wr), latch slot index, reg address, wr data and rd/wr type.
  - Slot index ≥ N_SLOTS, or rd & wr both set: go to RESP with err=1. No slot strobe.
  - Otherwise go to ACCESS.
- ACCESS: slot_cs_array[idx]=1 throughout. The strobe matching the request type is high on the first ACCESS cycle only. The timeout counter starts at 0 and increments each cycle.
  - slot_ack_array[idx]=1, including on the first cycle: capture slot_rd_data_array[idx] (reads only; writes capture 0), err=0, go to RESP.
  - Counter reaches TIMEOUT-1 without ack: rd_data ← all-ones, err=1, go to RESP.
  - Ack and timeout in the same cycle: ack wins.
- RESP: mmio_ready=1 for one cycle, mmio_err as latched, then go to IDLE.
- Requests presented outside IDLE are ignored. The master must hold off until mmio_ready.
- mmio_rd_data holds its last value between responses.
- Reset values: state IDLE, all slot arrays 0, reg address 0, wr data 0, mmio_rd_data 0, mmio_ready 0, mmio_err 0, counter 0.
- Reset mid-access: the access is abandoned at the next edge, strobes drop, and no response is issued.

## Timing
- Request sampled at edge E0. Strobe and cs are visible after E0, during cycle 1.
- Ack in cycle 1 gives mmio_ready in cycle 2: minimum latency 2 cycles from request to ready.
- Ack in ACCESS cycle k (1-based) gives ready in cycle k+1.
- Timeout: ready with err in cycle TIMEOUT+1.
- Error with no access: ready in cycle 1.
- All outputs are registered. The only combinational path is the selected ack/rd_data into capture registers.
- Back-to-back: a new request is accepted in the first IDLE cycle after RESP, giving a throughput of 1 access per 3 cycles minimum.

## Structure
- Package mmio_pkg holds:
  - state enum typedef
  - default widths: DW, REG_AW, SLOT_AW
  - error read value constant (all-ones)
- Sub-module mmio_timeout_ctr: loadable up-counter with terminal flag, sized $clog2(TIMEOUT).
- Decode, FSM and capture registers live in mmio_bridge.

## Test plan
- Read, N_SLOTS=64, addr slot 3 reg 5, slot 3 acks in cycle 1 with 0x1234_5678:
  - cs[3] high for 1 cycle, rd strobe 1 cycle, reg addr 5
  - ready in cycle 2 with data 0x1234_5678, err=0
- Write 0xCAFE_F00D to slot 10 reg 31, ack delayed to ACCESS cycle 4:
  - wr strobe only in cycle 1, cs[10] held cycles 1–4
  - ready in cycle 5, err=0
- Read of slot 7 with no ack, TIMEOUT=16:
  - ready in cycle 17, err=1, data 0xFFFF_FFFF
- N_SLOTS=8, request to slot 9:
  - no strobes, ready in cycle 1, err=1
- rd and wr asserted together:
  - err=1, ready in cycle 1
- Reset asserted in ACCESS cycle 2:
  - all outputs 0 after the edge, no ready
- Next request accepted normally after reset.

Source files
------------

// File: rtl/mmio_pkg.sv
// Shared types and defaults for the MMIO bridge: FSM states, default widths
// and the read value returned with an error response.
package mmio_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam int unsigned DEF_DW      = 32;
    localparam int unsigned DEF_REG_AW  = 5;
    localparam int unsigned DEF_SLOT_AW = 6;

    // Sliced down to DW by the bridge; supports data widths up to 64 bits.
    localparam logic [63:0] ERR_RD_VALUE = '1;

endpackage

// File: rtl/mmio_timeout_ctr.sv
// Watchdog counter for a slot access: loads zero while not counting and flags
// the cycle on which the count reaches TIMEOUT-1.
module mmio_timeout_ctr #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic enable,
    output logic terminal
);

    localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (reset || load) begin
            count <= '0;
        end else if (enable) begin
            count <= count + CW'(1);
        end
    end

    assign terminal = (count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/mmio_bridge.sv
// Registered FPro MMIO bridge: decodes one bus request at a time into slot
// strobes, waits for the selected slot's ack (or a timeout) and returns data.
module mmio_bridge
    import mmio_pkg::*;
#(
    parameter int unsigned N_SLOTS = 64,
    parameter int unsigned SLOT_AW = DEF_SLOT_AW,
    parameter int unsigned REG_AW  = DEF_REG_AW,
    parameter int unsigned DW      = DEF_DW,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            mmio_cs,
    input  logic                            mmio_rd,
    input  logic                            mmio_wr,
    input  logic [20:0]                     mmio_addr,
    input  logic [DW-1:0]                   mmio_wr_data,
    output logic [DW-1:0]                   mmio_rd_data,
    output logic                            mmio_ready,
    output logic                            mmio_err,
    output logic [N_SLOTS-1:0]              slot_cs_array,
    output logic [N_SLOTS-1:0]              slot_mem_rd_array,
    output logic [N_SLOTS-1:0]              slot_mem_wr_array,
    output logic [N_SLOTS-1:0][REG_AW-1:0]  slot_reg_addr_array,
    output logic [N_SLOTS-1:0][DW-1:0]      slot_wr_data_array,
    input  logic [N_SLOTS-1:0][DW-1:0]      slot_rd_data_array,
    input  logic [N_SLOTS-1:0]              slot_ack_array
);

    localparam int unsigned IDX_W     = $clog2(N_SLOTS);
    localparam int unsigned ADDR_USED = REG_AW + SLOT_AW;

    state_t              state;
    state_t              next_state;
    logic [SLOT_AW-1:0]  slot_field;
    logic                in_range;
    logic                req;
    logic                bad_req;
    logic [IDX_W-1:0]    idx;
    logic                is_rd;
    logic [REG_AW-1:0]   reg_addr;
    logic [DW-1:0]       wr_data;
    logic                rd_strb;
    logic                wr_strb;
    logic                ack;
    logic                terminal;

    assign slot_field = mmio_addr[ADDR_USED-1:REG_AW];
    assign in_range   = (32'(slot_field) < N_SLOTS);
    assign req        = mmio_cs & (mmio_rd | mmio_wr);
    assign bad_req    = ~in_range | (mmio_rd & mmio_wr);
    assign ack        = slot_ack_array[idx];

    generate
        if (ADDR_USED < 21) begin : g_upper_addr
            logic unused_addr;
            assign unused_addr = &{1'b0, mmio_addr[20:ADDR_USED]};
        end
    endgenerate

    mmio_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk      (clk),
        .reset    (reset),
        .load     (state != ACCESS),
        .enable   (state == ACCESS),
        .terminal (terminal)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (req) next_state = bad_req ? RESP : ACCESS;
            ACCESS:  if (ack || terminal) next_state = RESP;
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Request capture, strobe generation and response registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            idx           <= '0;
            is_rd         <= 1'b0;
            reg_addr      <= '0;
            wr_data       <= '0;
            slot_cs_array <= '0;
            rd_strb       <= 1'b0;
            wr_strb       <= 1'b0;
            mmio_rd_data  <= '0;
            mmio_ready    <= 1'b0;
            mmio_err      <= 1'b0;
        end else begin
            rd_strb    <= 1'b0;
            wr_strb    <= 1'b0;
            mmio_ready <= 1'b0;
            mmio_err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (req) begin
                        idx      <= slot_field[IDX_W-1:0];
                        is_rd    <= mmio_rd;
                        reg_addr <= mmio_addr[REG_AW-1:0];
                        wr_data  <= mmio_wr_data;
                        if (bad_req) begin
                            mmio_ready <= 1'b1;
                            mmio_err   <= 1'b1;
                        end else begin
                            slot_cs_array <= N_SLOTS'(1) << slot_field[IDX_W-1:0];
                            rd_strb       <= mmio_rd;
                            wr_strb       <= mmio_wr;
                        end
                    end
                end
                ACCESS: begin
                    // An ack on the timeout cycle still completes normally.
                    if (ack) begin
                        slot_cs_array <= '0;
                        mmio_rd_data  <= is_rd ? slot_rd_data_array[idx] : '0;
                        mmio_ready    <= 1'b1;
                    end else if (terminal) begin
                        slot_cs_array <= '0;
                        mmio_rd_data  <= ERR_RD_VALUE[DW-1:0];
                        mmio_ready    <= 1'b1;
                        mmio_err      <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign slot_mem_rd_array   = {N_SLOTS{rd_strb}};
    assign slot_mem_wr_array   = {N_SLOTS{wr_strb}};
    assign slot_reg_addr_array = {N_SLOTS{reg_addr}};
    assign slot_wr_data_array  = {N_SLOTS{wr_data}};

endmodule

// File: tb/tb_mmio_bridge.sv
// Bench for mmio_bridge: directed and random transactions against a
// transaction-level model of latency, strobes, error and read data.
module tb_mmio_bridge;

    localparam int NS  = 48;
    localparam int TO  = 16;
    localparam int DW  = 32;
    localparam int RAW = 5;

    localparam logic [NS-1:0] ALL_SLOTS = '1;

    logic                      clk;
    logic                      reset;
    logic                      mmio_cs;
    logic                      mmio_rd;
    logic                      mmio_wr;
    logic [20:0]               mmio_addr;
    logic [DW-1:0]             mmio_wr_data;
    logic [DW-1:0]             mmio_rd_data;
    logic                      mmio_ready;
    logic                      mmio_err;
    logic [NS-1:0]             slot_cs_array;
    logic [NS-1:0]             slot_mem_rd_array;
    logic [NS-1:0]             slot_mem_wr_array;
    logic [NS-1:0][RAW-1:0]    slot_reg_addr_array;
    logic [NS-1:0][DW-1:0]     slot_wr_data_array;
    logic [NS-1:0][DW-1:0]     slot_rd_data_array;
    logic [NS-1:0]             slot_ack_array;

    int n_total;
    int n_bad;
    logic [DW-1:0] held_rd;

    mmio_bridge #(
        .N_SLOTS (NS),
        .SLOT_AW (6),
        .REG_AW  (RAW),
        .DW      (DW),
        .TIMEOUT (TO)
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .mmio_cs             (mmio_cs),
        .mmio_rd             (mmio_rd),
        .mmio_wr             (mmio_wr),
        .mmio_addr           (mmio_addr),
        .mmio_wr_data        (mmio_wr_data),
        .mmio_rd_data        (mmio_rd_data),
        .mmio_ready          (mmio_ready),
        .mmio_err            (mmio_err),
        .slot_cs_array       (slot_cs_array),
        .slot_mem_rd_array   (slot_mem_rd_array),
        .slot_mem_wr_array   (slot_mem_wr_array),
        .slot_reg_addr_array (slot_reg_addr_array),
        .slot_wr_data_array  (slot_wr_data_array),
        .slot_rd_data_array  (slot_rd_data_array),
        .slot_ack_array      (slot_ack_array)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: sim time exceeded, got no finish, required finish before 1ms");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic drive_slots(input int sel, input bit ack_sel, input logic [DW-1:0] sel_data);
        logic [63:0] r64;
        r64 = {$urandom(), $urandom()};
        slot_ack_array = r64[NS-1:0];
        for (int i = 0; i < NS; i++) slot_rd_data_array[i] = $urandom();
        if (sel < NS) begin
            slot_ack_array[sel]     = ack_sel;
            slot_rd_data_array[sel] = sel_data;
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int g = 0; g < n; g++) begin
            drive_slots(NS, 1'b0, '0);
            @(negedge clk);
            check_eq("idle_ready", 64'(mmio_ready), 64'd0);
            check_eq("idle_cs", 64'(slot_cs_array), 64'd0);
            @(posedge clk); #1;
        end
        slot_ack_array = '0;
    endtask

    // Called at posedge+1 of an IDLE cycle; returns at posedge+1 of the first
    // IDLE cycle after the response, so consecutive calls are back-to-back.
    task automatic run_txn(input int sel, input int reg_a, input bit rd, input bit wr,
                           input logic [DW-1:0] wdata, input logic [DW-1:0] rdata,
                           input int k, input bit junk);
        bit            bad;
        int            ready_c;
        int            last_cs;
        bit            exp_err;
        logic [DW-1:0] new_rd;
        bit            acc_c;
        bad = (sel >= NS) || (rd && wr);
        if (bad) begin
            ready_c = 1; last_cs = 0; exp_err = 1'b1; new_rd = held_rd;
        end else if (k <= TO) begin
            ready_c = k + 1; last_cs = k; exp_err = 1'b0; new_rd = rd ? rdata : '0;
        end else begin
            ready_c = TO + 1; last_cs = TO; exp_err = 1'b1; new_rd = '1;
        end
        mmio_cs      = 1'b1;
        mmio_rd      = rd;
        mmio_wr      = wr;
        mmio_addr    = {10'($urandom()), 6'(sel), 5'(reg_a)};
        mmio_wr_data = wdata;
        drive_slots(sel, 1'b0, '0);
        @(posedge clk); #1;
        for (int c = 1; c <= ready_c; c++) begin
            if (junk) begin
                mmio_cs      = 1'b1;
                mmio_rd      = 1'($urandom_range(0, 1));
                mmio_wr      = ~mmio_rd | 1'($urandom_range(0, 1));
                mmio_addr    = 21'($urandom());
                mmio_wr_data = $urandom();
            end else begin
                mmio_cs = 1'b0;
            end
            drive_slots(sel, (c == k), (c == k) ? rdata : $urandom());
            @(negedge clk);
            acc_c = (c <= last_cs);
            check_eq("cs", 64'(slot_cs_array), acc_c ? (64'd1 << sel) : 64'd0);
            check_eq("rd_strobe", 64'(slot_mem_rd_array),
                     (c == 1 && !bad && rd) ? 64'(ALL_SLOTS) : 64'd0);
            check_eq("wr_strobe", 64'(slot_mem_wr_array),
                     (c == 1 && !bad && wr) ? 64'(ALL_SLOTS) : 64'd0);
            if (acc_c) begin
                check_eq("reg_addr_sel", 64'(slot_reg_addr_array[sel]), 64'(reg_a));
                check_eq("reg_addr_0", 64'(slot_reg_addr_array[0]), 64'(reg_a));
                check_eq("wr_data_sel", 64'(slot_wr_data_array[sel]), 64'(wdata));
            end
            check_eq("ready", 64'(mmio_ready), 64'(c == ready_c));
            check_eq("err", 64'(mmio_err), 64'(c == ready_c && exp_err));
            check_eq("rd_data", 64'(mmio_rd_data), 64'((c == ready_c) ? new_rd : held_rd));
            @(posedge clk); #1;
        end
        mmio_cs        = 1'b0;
        mmio_rd        = 1'b0;
        mmio_wr        = 1'b0;
        slot_ack_array = '0;
        held_rd        = new_rd;
    endtask

    task automatic reset_mid_access();
        mmio_cs      = 1'b1;
        mmio_rd      = 1'b1;
        mmio_wr      = 1'b0;
        mmio_addr    = {10'd0, 6'd5, 5'd9};
        mmio_wr_data = 32'h5555_AAAA;
        slot_ack_array = '0;
        @(posedge clk); #1;
        mmio_cs = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        check_eq("rst_pre_cs", 64'(slot_cs_array), 64'd1 << 5);
        reset = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check_eq("rst_cs", 64'(slot_cs_array), 64'd0);
        check_eq("rst_strobes", 64'(slot_mem_rd_array | slot_mem_wr_array), 64'd0);
        check_eq("rst_ready", 64'(mmio_ready), 64'd0);
        check_eq("rst_err", 64'(mmio_err), 64'd0);
        check_eq("rst_rd_data", 64'(mmio_rd_data), 64'd0);
        check_eq("rst_reg_addr", 64'(slot_reg_addr_array[5]), 64'd0);
        check_eq("rst_wr_data", 64'(slot_wr_data_array[5]), 64'd0);
        reset = 1'b0;
        @(posedge clk); #1;
        held_rd = '0;
        idle_cycles(TO + 2);
    endtask

    initial begin
        n_total = 0;
        n_bad   = 0;
        held_rd = '0;
        reset   = 1'b1;
        mmio_cs = 1'b0;
        mmio_rd = 1'b0;
        mmio_wr = 1'b0;
        mmio_addr = '0;
        mmio_wr_data = '0;
        slot_ack_array = '0;
        slot_rd_data_array = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("init_ready", 64'(mmio_ready), 64'd0);
        check_eq("init_err", 64'(mmio_err), 64'd0);
        check_eq("init_rd_data", 64'(mmio_rd_data), 64'd0);
        check_eq("init_cs", 64'(slot_cs_array), 64'd0);
        check_eq("init_strobes", 64'(slot_mem_rd_array | slot_mem_wr_array), 64'd0);
        check_eq("init_reg_addr", 64'(slot_reg_addr_array[0]), 64'd0);
        check_eq("init_wr_data", 64'(slot_wr_data_array[0]), 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        run_txn(3, 5, 1'b1, 1'b0, 32'h0BAD_0BAD, 32'h1234_5678, 1, 1'b0);
        run_txn(10, 31, 1'b0, 1'b1, 32'hCAFE_F00D, 32'h0, 4, 1'b0);
        run_txn(7, 2, 1'b1, 1'b0, 32'h0, 32'h0, TO + 5, 1'b0);
        run_txn(50, 1, 1'b1, 1'b0, 32'h0, 32'h0, 1, 1'b0);
        run_txn(63, 0, 1'b0, 1'b1, 32'h1111_2222, 32'h0, 1, 1'b0);
        run_txn(NS - 1, 12, 1'b1, 1'b0, 32'h0, 32'hA5A5_5A5A, 2, 1'b0);
        run_txn(4, 4, 1'b1, 1'b1, 32'h0, 32'h0, 1, 1'b0);
        run_txn(20, 6, 1'b1, 1'b0, 32'h0, 32'hDEAD_BEEF, TO, 1'b1);
        run_txn(21, 7, 1'b1, 1'b0, 32'h0, 32'h0BEE_F00D, TO - 1, 1'b1);
        reset_mid_access();
        run_txn(12, 7, 1'b1, 1'b0, 32'h0, 32'h7777_0001, 2, 1'b0);

        for (int t = 0; t < 40; t++) begin
            int  sel;
            int  op;
            bit  rd;
            bit  wr;
            sel = $urandom_range(0, 63);
            op  = $urandom_range(0, 9);
            rd  = (op < 5) || (op == 9);
            wr  = (op >= 5);
            run_txn(sel, $urandom_range(0, 31), rd, wr, $urandom(), $urandom(),
                    $urandom_range(1, TO + 2), 1'($urandom_range(0, 1)));
            idle_cycles($urandom_range(0, 2));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
